// File: rtl/vec_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vec_alu_unit
//  Description : Multi-cycle vector ALU. It captures two vector operands and a
//                scalar, then computes LANES_PER_CYC lanes per BUSY cycle,
//                lowest lanes first. It gives a one-cycle alu_rdy strobe in
//                DONE.
//                Optional macro VEC_ALU_SAT_EN: saturating add/sub (ops
//                1010..1101). When it is undefined these ops wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_alu_unit #(
    parameter int VEC_LANES     = 16,
    parameter int LANE_W        = 8,
    parameter int LANES_PER_CYC = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          alu_st,
    input  logic [3:0]                    alu_op,
    input  logic [VEC_LANES*LANE_W-1:0]   vec_a,
    input  logic [VEC_LANES*LANE_W-1:0]   vec_b,
    input  logic [LANE_W-1:0]             esc,
    output logic [VEC_LANES*LANE_W-1:0]   alu_res,
    output logic                          alu_rdy
);

    localparam int c_VEC_W = VEC_LANES * LANE_W;
    localparam int c_GRP_W = LANES_PER_CYC * LANE_W;
    localparam int c_CNT_W = $clog2(VEC_LANES + 1);
    localparam logic [c_CNT_W-1:0] c_STEP     = c_CNT_W'(LANES_PER_CYC);
    localparam logic [c_CNT_W-1:0] c_LAST_CNT = c_CNT_W'(VEC_LANES - LANES_PER_CYC);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [c_CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]           op_q, op_d;
    logic [c_VEC_W-1:0]   a_q, a_d;
    logic [c_VEC_W-1:0]   b_q, b_d;
    logic [LANE_W-1:0]    esc_q, esc_d;
    logic [c_VEC_W-1:0]   res_q, res_d;
    logic [c_GRP_W-1:0]   w_grp_res;

    // Single-lane operation. Carries and borrows stay inside the lane.
    function automatic logic [LANE_W-1:0] lane_op(
        input logic [3:0]        op,
        input logic [LANE_W-1:0] a,
        input logic [LANE_W-1:0] b,
        input logic [LANE_W-1:0] s
    );
        logic [2:0] sh;
`ifdef VEC_ALU_SAT_EN
        logic [LANE_W:0] ext;
`endif
        sh      = s[2:0];
        lane_op = '0;
        case (op)
            4'b0000: lane_op = a & s;
            4'b0001: lane_op = a & b;
            4'b0010: lane_op = a | s;
            4'b0011: lane_op = a | b;
            4'b0100: lane_op = a ^ s;
            4'b0101: lane_op = a ^ b;
            4'b0110: lane_op = a >> sh;
            4'b0111: lane_op = a << sh;
            // A shift of LANE_W clears every bit, so a rotate by 0 returns the lane unchanged.
            4'b1000: lane_op = (a >> sh) | (a << (LANE_W - int'(sh)));
            4'b1001: lane_op = (a << sh) | (a >> (LANE_W - int'(sh)));
`ifdef VEC_ALU_SAT_EN
            4'b1010: begin
                ext     = {1'b0, a} + {1'b0, b};
                lane_op = ext[LANE_W] ? '1 : ext[LANE_W-1:0];
            end
            4'b1011: begin
                ext     = {1'b0, a} + {1'b0, s};
                lane_op = ext[LANE_W] ? '1 : ext[LANE_W-1:0];
            end
            4'b1100: begin
                ext     = {1'b0, a} - {1'b0, b};
                lane_op = ext[LANE_W] ? '0 : ext[LANE_W-1:0];
            end
            4'b1101: begin
                ext     = {1'b0, a} - {1'b0, s};
                lane_op = ext[LANE_W] ? '0 : ext[LANE_W-1:0];
            end
`else
            4'b1010: lane_op = a + b;
            4'b1011: lane_op = a + s;
            4'b1100: lane_op = a - b;
            4'b1101: lane_op = a - s;
`endif
            default: lane_op = '0;
        endcase
    endfunction

    // One datapath slice per lane of the group selected by the lane counter.
    for (genvar j = 0; j < LANES_PER_CYC; j++) begin : g_lane
        logic [c_CNT_W-1:0] w_idx;
        assign w_idx = cnt_q + c_CNT_W'(j);
        assign w_grp_res[j*LANE_W +: LANE_W] =
            lane_op(op_q, a_q[w_idx*LANE_W +: LANE_W], b_q[w_idx*LANE_W +: LANE_W], esc_q);
    end

    // Next-state logic: operand capture, lane-group writes, and state sequencing.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        esc_d   = esc_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (alu_st) begin
                    op_d    = alu_op;
                    a_d     = vec_a;
                    b_d     = vec_b;
                    esc_d   = esc;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                res_d[cnt_q*LANE_W +: c_GRP_W] = w_grp_res;
                if (cnt_q == c_LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d   = cnt_q + c_STEP;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers. Reset clears everything and aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            esc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            esc_q   <= esc_d;
            res_q   <= res_d;
        end
    end

    assign alu_res = res_q;
    assign alu_rdy = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_vec_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_alu_unit
//  Description : Scoreboard bench for vec_alu_unit. Expected vectors are
//                queued at start and compared when alu_rdy appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_alu_unit;

    localparam int VEC_LANES     = 16;
    localparam int LANE_W        = 8;
    localparam int LANES_PER_CYC = 4;
    localparam int c_VW          = VEC_LANES * LANE_W;
    localparam int c_MASK        = (1 << LANE_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              alu_st;
    logic [3:0]        alu_op;
    logic [c_VW-1:0]   vec_a;
    logic [c_VW-1:0]   vec_b;
    logic [LANE_W-1:0] esc;
    logic [c_VW-1:0]   alu_res;
    logic              alu_rdy;

    logic [c_VW-1:0]   sbq[$];
    int                total = 0;
    int                bad   = 0;

    vec_alu_unit #(
        .VEC_LANES     (VEC_LANES),
        .LANE_W        (LANE_W),
        .LANES_PER_CYC (LANES_PER_CYC)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .alu_st  (alu_st),
        .alu_op  (alu_op),
        .vec_a   (vec_a),
        .vec_b   (vec_b),
        .esc     (esc),
        .alu_res (alu_res),
        .alu_rdy (alu_rdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [c_VW-1:0] obs, input logic [c_VW-1:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference lane model, written with integer arithmetic.
    function automatic int ref_lane(input int op, input int a, input int b, input int s);
        int k;
        int r;
        int t;
        k = s & 7;
        r = 0;
        case (op)
            0:  r = a & s;
            1:  r = a & b;
            2:  r = a | s;
            3:  r = a | b;
            4:  r = a ^ s;
            5:  r = a ^ b;
            6:  r = a / (1 << k);
            7:  r = (a * (1 << k)) & c_MASK;
            8:  begin
                r = a;
                for (int i = 0; i < k; i++) r = (r >> 1) | ((r & 1) << (LANE_W - 1));
            end
            9:  begin
                r = a;
                for (int i = 0; i < k; i++) r = ((r << 1) & c_MASK) | (r >> (LANE_W - 1));
            end
            10, 11: begin
                t = a + ((op == 10) ? b : s);
`ifdef VEC_ALU_SAT_EN
                r = (t > c_MASK) ? c_MASK : t;
`else
                r = t & c_MASK;
`endif
            end
            12, 13: begin
                t = a - ((op == 12) ? b : s);
`ifdef VEC_ALU_SAT_EN
                r = (t < 0) ? 0 : t;
`else
                r = (t + c_MASK + 1) & c_MASK;
`endif
            end
            default: r = 0;
        endcase
        return r;
    endfunction

    function automatic logic [c_VW-1:0] ref_vec(input logic [3:0] op, input logic [c_VW-1:0] a,
                                                input logic [c_VW-1:0] b, input logic [LANE_W-1:0] s);
        logic [c_VW-1:0] v;
        v = '0;
        for (int l = 0; l < VEC_LANES; l++)
            v[l*LANE_W +: LANE_W] = LANE_W'(ref_lane(int'(op), int'(a[l*LANE_W +: LANE_W]),
                                                     int'(b[l*LANE_W +: LANE_W]), int'(s)));
        return v;
    endfunction

    function automatic logic [c_VW-1:0] rand_vec();
        logic [c_VW-1:0] v;
        for (int w = 0; w < c_VW / 32; w++) v[w*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [c_VW-1:0] sb_pop();
        if (sbq.size() == 0) return 'x;
        return sbq.pop_front();
    endfunction

    // One operation: start, optional disturbance while BUSY, latency, result, pulse and hold.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [c_VW-1:0] a,
                          input logic [c_VW-1:0] b, input logic [LANE_W-1:0] s, input bit disturb);
        int n;
        bit got;
        logic [c_VW-1:0] exp;
        alu_op = op;
        vec_a  = a;
        vec_b  = b;
        esc    = s;
        alu_st = 1'b1;
        sbq.push_back(ref_vec(op, a, b, s));
        tick();
        alu_st = 1'b0;
        n   = 0;
        got = 1'b0;
        while (n < 12 && !got) begin
            if (disturb) begin
                alu_st = 1'($urandom_range(0, 1));
                alu_op = 4'($urandom_range(0, 15));
                vec_a  = rand_vec();
                vec_b  = rand_vec();
                esc    = LANE_W'($urandom);
            end
            tick();
            n++;
            got = alu_rdy;
        end
        alu_st = 1'b0;
        check({tag, "_lat"}, c_VW'(n), c_VW'(VEC_LANES / LANES_PER_CYC));
        exp = sb_pop();
        check({tag, "_res"}, alu_res, exp);
        tick();
        check({tag, "_pulse"}, c_VW'(alu_rdy), '0);
        check({tag, "_hold"}, alu_res, exp);
    endtask

    initial begin
        int n;
        int pulses;
        bit got;
        logic [c_VW-1:0] a;
        logic [c_VW-1:0] b;
        logic [c_VW-1:0] exp;
        logic [c_VW-1:0] cval;

        rst    = 1'b1;
        alu_st = 1'b0;
        alu_op = '0;
        vec_a  = '0;
        vec_b  = '0;
        esc    = '0;
        tick();
        tick();
        check("rst_res", alu_res, '0);
        check("rst_rdy", c_VW'(alu_rdy), '0);

        // Reset wins over a simultaneous start request.
        alu_st = 1'b1;
        alu_op = 4'b0011;
        vec_a  = '1;
        tick();
        rst    = 1'b0;
        alu_st = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (alu_rdy) pulses++;
        end
        check("rst_prio_nordy", c_VW'(pulses), '0);
        check("rst_prio_res", alu_res, '0);

        // Add with overflow in every lane.
        run_op("add_ovf", 4'b1010, {VEC_LANES{8'hF0}}, {VEC_LANES{8'h20}}, 8'h00, 1'b0);
`ifdef VEC_ALU_SAT_EN
        cval = {VEC_LANES{8'hFF}};
`else
        cval = {VEC_LANES{8'h10}};
`endif
        check("add_ovf_const", alu_res, cval);

        // Rotate left and logical right shift by 3.
        run_op("rotl", 4'b1001, {VEC_LANES{8'h81}}, '0, 8'h03, 1'b0);
        cval = {VEC_LANES{8'h0C}};
        check("rotl_const", alu_res, cval);
        run_op("shr", 4'b0110, {VEC_LANES{8'h81}}, '0, 8'h03, 1'b0);
        cval = {VEC_LANES{8'h10}};
        check("shr_const", alu_res, cval);

        // Subtract scalar with underflow in the low lanes.
        for (int l = 0; l < VEC_LANES; l++) a[l*LANE_W +: LANE_W] = LANE_W'(l);
        run_op("sub_s", 4'b1101, a, '0, 8'h05, 1'b0);
`ifdef VEC_ALU_SAT_EN
        check("sub_s_l0", c_VW'(alu_res[7:0]), c_VW'(8'h00));
        check("sub_s_l4", c_VW'(alu_res[39:32]), c_VW'(8'h00));
`else
        check("sub_s_l0", c_VW'(alu_res[7:0]), c_VW'(8'hFB));
        check("sub_s_l4", c_VW'(alu_res[39:32]), c_VW'(8'hFF));
`endif
        check("sub_s_l5", c_VW'(alu_res[47:40]), c_VW'(8'h00));
        check("sub_s_l15", c_VW'(alu_res[127:120]), c_VW'(8'h0A));

        // Every op code once with random operands; some runs disturb inputs while BUSY.
        for (int i = 0; i < 16; i++) begin
            run_op($sformatf("op%0d", i), 4'(i), rand_vec(), rand_vec(),
                   (i % 3 == 0) ? LANE_W'(0) : LANE_W'($urandom), (i % 4 == 3));
        end
        run_op("rotr0", 4'b1000, rand_vec(), '0, 8'hF8, 1'b0);

        // Abort: reset on the second BUSY cycle.
        alu_op = 4'b0001;
        vec_a  = rand_vec();
        vec_b  = rand_vec();
        alu_st = 1'b1;
        sbq.push_back(ref_vec(alu_op, vec_a, vec_b, esc));
        tick();
        alu_st = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        void'(sb_pop());
        check("abort_res", alu_res, '0);
        check("abort_rdy", c_VW'(alu_rdy), '0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (alu_rdy) pulses++;
        end
        check("abort_nordy", c_VW'(pulses), '0);
        run_op("after_abort", 4'b0101, rand_vec(), rand_vec(), 8'h00, 1'b0);

        // Back-to-back operations with alu_st held high.
        a      = rand_vec();
        b      = rand_vec();
        alu_op = 4'b0011;
        vec_a  = a;
        vec_b  = b;
        alu_st = 1'b1;
        sbq.push_back(ref_vec(4'b0011, a, b, esc));
        tick();
        n   = 0;
        got = 1'b0;
        while (n < 12 && !got) begin
            tick();
            n++;
            got = alu_rdy;
        end
        check("b2b_lat", c_VW'(n), c_VW'(VEC_LANES / LANES_PER_CYC));
        exp = sb_pop();
        check("b2b_res1", alu_res, exp);
        alu_op = 4'b1110;
        sbq.push_back(ref_vec(4'b1110, a, b, esc));
        n   = 0;
        got = 1'b0;
        while (n < 14 && !got) begin
            tick();
            n++;
            got = alu_rdy;
        end
        check("b2b_gap", c_VW'(n), c_VW'(VEC_LANES / LANES_PER_CYC + 1));
        exp = sb_pop();
        check("b2b_res2", alu_res, exp);
        check("b2b_zero", alu_res, '0);
        alu_st = 1'b0;
        tick();
        check("b2b_end_rdy", c_VW'(alu_rdy), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/vec_alu_unit.md
VEC_ALU_UNIT -- requirements
Module: vec_alu_unit

Interface
REQ-001 SHALL have parameter VEC_LANES, 16, number of lanes per vector.
REQ-002 SHALL have parameter LANE_W, 8, lane width in bits.
REQ-003 SHALL have parameter LANES_PER_CYC, 4, lanes processed per BUSY cycle; VEC_LANES SHALL be a multiple of it.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port alu_st  input  1  start request, driven by processor control cl_alu_st.
REQ-007 SHALL have port alu_op  input  4  operation code, driven by processor control cl_alu_op.
REQ-008 SHALL have port vec_a  input  VEC_LANES*LANE_W  first vector operand; lane i at bits [i*LANE_W +: LANE_W].
REQ-009 SHALL have port vec_b  input  VEC_LANES*LANE_W  second vector operand, same packing.
REQ-010 SHALL have port esc  input  LANE_W  scalar operand.
REQ-011 SHALL have port alu_res  output  VEC_LANES*LANE_W  result vector, registered.
REQ-012 SHALL have port alu_rdy  output  1  completion strobe, consumed by processor control.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 IDLE or DONE with alu_st=1: SHALL capture alu_op, vec_a, vec_b, esc; clear lane counter; enter BUSY next cycle.
REQ-015 DONE with alu_st=0 SHALL go to IDLE; IDLE with alu_st=0 SHALL stay in IDLE.
REQ-016 alu_st in BUSY SHALL be ignored; captured operands SHALL NOT change.
REQ-017 BUSY SHALL compute and write LANES_PER_CYC lanes per cycle, lowest lanes first; counter advances by LANES_PER_CYC.
REQ-018 After writing the last lane group, SHALL enter DONE; BUSY lasts exactly VEC_LANES/LANES_PER_CYC cycles (4 by default).
REQ-019 alu_rdy SHALL be 1 only in DONE (one-cycle pulse per operation); latency start-sample edge to alu_rdy high = VEC_LANES/LANES_PER_CYC+1 edges.
REQ-020 alu_res SHALL hold final value from DONE until the next operation starts writing lanes; partial updates allowed only in BUSY.
REQ-021 Per-lane ops ("s" = esc, "b" = vec_b lane): 0000 a&s; 0001 a&b; 0010 a|s; 0011 a|b; 0100 a^s; 0101 a^b.
REQ-022 0110 logical right shift of lane by esc[2:0]; 0111 logical left shift of lane by esc[2:0]; zero fill.
REQ-023 1000 rotate lane right by esc[2:0]; 1001 rotate lane left by esc[2:0]; shift/rotate amount 0 returns lane unchanged.
REQ-024 1010 a+b; 1011 a+s; 1100 a-b; 1101 a-s; modulo 2^LANE_W (wrap) unless REQ-030 applies.
REQ-025 Codes 1110, 1111 SHALL produce all-zero lanes and still complete with normal latency.
REQ-026 All arithmetic unsigned; carries/borrows SHALL NOT cross lane boundaries.

Reset
REQ-027 rst=1 at a rising edge SHALL force IDLE, alu_res=0, alu_rdy=0, counter=0, captured operands=0.
REQ-028 rst in BUSY or DONE SHALL abort the operation; no alu_rdy pulse for it.
REQ-029 rst has priority over alu_st in the same cycle.

Configuration
REQ-030 Macro VEC_ALU_SAT_EN defined: ops 1010/1011 SHALL clamp to 2^LANE_W-1 on overflow; ops 1100/1101 SHALL clamp to 0 on underflow.
REQ-031 Macro VEC_ALU_SAT_EN undefined: ops 1010-1101 SHALL wrap modulo 2^LANE_W; all other behaviour identical.

Verification
REQ-032 After reset, alu_st=1, op=1010, all a lanes=0xF0, b lanes=0x20 -> alu_rdy high exactly on 5th edge after start, every lane 0x10 (0xFF with VEC_ALU_SAT_EN).
REQ-033 op=1001, a lanes=0x81, esc=0x03 -> every lane 0x0C; op=0110 same inputs -> every lane 0x10.
REQ-034 op=1101, a lane i=i, esc=0x05 -> lanes 0..4 = 0xFB..0xFF (0x00 with VEC_ALU_SAT_EN), lane 5=0x00, lane 15=0x0A.
REQ-035 Start op=0001, assert rst on 2nd BUSY cycle -> next cycle IDLE, alu_res=0, no alu_rdy pulse; fresh start then completes normally.
REQ-036 alu_st held high continuously, op=0011 then op=1110 presented in DONE -> back-to-back ops, alu_rdy pulses 5 cycles apart, second result all zeros.
REQ-037 alu_st toggled during BUSY with different operands -> result reflects only originally captured operands.
